// File: rtl/mac_pkg.sv
// Shared definitions for the mac_16bit operand-side driver.
package mac_pkg;

  localparam int MAC_OP_W        = 16;
  localparam int MAC_RES_W       = 27;
  localparam int MAC_FRAME_LEN   = 256;
  localparam int MAC_CAPTURE_LAT = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RESULT
  } mac_drv_state_t;

endpackage

// File: rtl/mac_stream_driver.sv
// Operand-side driver for mac_16bit: frames one operand vector per MAC run,
// zero-pads unused slots and returns the rounded dot product.
// Optional build macro MAC_DRV_STATS_EN adds res_bubbles (bubble slot count).
//
//  state  | meaning
//  IDLE   | waiting for the first pair of a vector (s_ready=0)
//  CLEAR  | one cycle; next cycle mac_rst is low and operands are zero
//  STREAM | FRAME_LEN slots, one per cycle; accepted pair or (0,0)
//  DRAIN  | zero operands while the MAC pipeline settles; latch mac_out on exit
//  RESULT | res_valid high until consumed (and overflow tail discarded)
module mac_stream_driver
  import mac_pkg::*;
#(
  parameter int FRAME_LEN   = MAC_FRAME_LEN,
  parameter int CAPTURE_LAT = MAC_CAPTURE_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MAC_OP_W-1:0]  s_md,
  input  logic [MAC_OP_W-1:0]  s_mr,
  input  logic                 s_last,
  output logic                 mac_rst,
  output logic [MAC_OP_W-1:0]  mac_md,
  output logic [MAC_OP_W-1:0]  mac_mr,
  input  logic [MAC_RES_W-1:0] mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MAC_RES_W-1:0] res_data,
  output logic                 res_err
`ifdef MAC_DRV_STATS_EN
  ,
  output logic [8:0]           res_bubbles
`endif
);

  localparam int SLOT_W  = $clog2(FRAME_LEN + 1);
  localparam int DRAIN_W = $clog2(CAPTURE_LAT + 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(CAPTURE_LAT);

  mac_drv_state_t       state_q, state_d;
  logic [SLOT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [MAC_OP_W-1:0]  md_q, md_d, mr_q, mr_d;
  logic                 mac_rst_q, mac_rst_d;
  logic                 last_seen_q, last_seen_d;
  logic [MAC_RES_W-1:0] res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic                 accept;
`ifdef MAC_DRV_STATS_EN
  logic [8:0]           bub_cnt_q, bub_cnt_d;
  logic [8:0]           res_bub_q, res_bub_d;
`endif

  // Next-state, slot framing and handshake decode.
  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    drain_cnt_d = drain_cnt_q;
    md_d        = '0;
    mr_d        = '0;
    last_seen_d = last_seen_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    s_ready     = 1'b0;
    res_valid   = 1'b0;
`ifdef MAC_DRV_STATS_EN
    bub_cnt_d   = bub_cnt_q;
    res_bub_d   = res_bub_q;
`endif
    // The MAC clear lands in the cycle after CLEAR so that it directly
    // precedes the first slot appearing on mac_md/mac_mr.
    mac_rst_d   = (state_q != CLEAR);

    case (state_q)
      IDLE: begin
        if (s_valid) state_d = CLEAR;
      end
      CLEAR: begin
        state_d     = STREAM;
        slot_cnt_d  = '0;
        last_seen_d = 1'b0;
        res_err_d   = 1'b0;
`ifdef MAC_DRV_STATS_EN
        bub_cnt_d   = '0;
`endif
      end
      STREAM: begin
        s_ready = !last_seen_q;
        if (s_valid && !last_seen_q) begin
          md_d = s_md;
          mr_d = s_mr;
          if (s_last) last_seen_d = 1'b1;
        end
`ifdef MAC_DRV_STATS_EN
        else if (!last_seen_q) begin
          bub_cnt_d = bub_cnt_q + 9'd1;
        end
`endif
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q == SLOT_LAST) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
          if (!last_seen_d) res_err_d = 1'b1;
        end
      end
      DRAIN: begin
        // After an overflow the tail of the vector is drained and dropped.
        s_ready     = res_err_q && !last_seen_q;
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DRAIN_END) begin
          state_d    = RESULT;
          res_data_d = mac_out;
`ifdef MAC_DRV_STATS_EN
          res_bub_d  = bub_cnt_q;
`endif
        end
      end
      RESULT: begin
        s_ready   = res_err_q && !last_seen_q;
        res_valid = 1'b1;
        if (res_ready && last_seen_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = s_valid && s_ready;
    if (accept && s_last) last_seen_d = 1'b1;
  end

  // State, counters and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      slot_cnt_q  <= '0;
      drain_cnt_q <= '0;
      md_q        <= '0;
      mr_q        <= '0;
      mac_rst_q   <= 1'b0;
      last_seen_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
`ifdef MAC_DRV_STATS_EN
      bub_cnt_q   <= '0;
      res_bub_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      md_q        <= md_d;
      mr_q        <= mr_d;
      mac_rst_q   <= mac_rst_d;
      last_seen_q <= last_seen_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
`ifdef MAC_DRV_STATS_EN
      bub_cnt_q   <= bub_cnt_d;
      res_bub_q   <= res_bub_d;
`endif
    end
  end

  assign mac_rst  = mac_rst_q;
  assign mac_md   = md_q;
  assign mac_mr   = mr_q;
  assign res_data = res_data_q;
  assign res_err  = res_err_q;
`ifdef MAC_DRV_STATS_EN
  assign res_bubbles = res_bub_q;
`endif

endmodule

// File: tb/tb_mac_stream_driver.sv
// Bench for mac_stream_driver with a behavioural mac_16bit model and a
// result scoreboard. Honours MAC_DRV_STATS_EN when defined.
module tb_mac_stream_driver;

  localparam int FRAME_LEN = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_md, s_mr;
  logic        mac_rst;
  logic [15:0] mac_md, mac_mr;
  logic [26:0] mac_out;
  logic        res_valid, res_ready, res_err;
  logic [26:0] res_data;
`ifdef MAC_DRV_STATS_EN
  logic [8:0]  res_bubbles;
`endif

  always #5 clk = ~clk;

  mac_stream_driver dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_md      (s_md),
    .s_mr      (s_mr),
    .s_last    (s_last),
    .mac_rst   (mac_rst),
    .mac_md    (mac_md),
    .mac_mr    (mac_mr),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
`ifdef MAC_DRV_STATS_EN
    ,
    .res_bubbles (res_bubbles)
`endif
  );

  function automatic logic [26:0] rnd(input logic signed [39:0] a);
    logic signed [39:0] t;
    t = (a + 40'sd4096) >>> 13;
    return t[26:0];
  endfunction

  // mac_16bit model: clear on mac_rst low, accumulate, 3 further stages
  // so mac_out holds the sum 4 cycles after the last slot is driven.
  logic signed [39:0] acc = '0;
  logic signed [31:0] prod;
  logic [26:0] p1 = '0, p2 = '0, p3 = '0;
  assign prod    = $signed(mac_md) * $signed(mac_mr);
  assign mac_out = p3;
  always @(posedge clk) begin
    if (!mac_rst) acc <= '0;
    else          acc <= acc + {{8{prod[31]}}, prod};
    p1 <= rnd(acc);
    p2 <= p1;
    p3 <= p2;
  end

  int n_checks = 0;
  int n_errors = 0;
  int rst_lo_cnt = 0;
  int nz_cnt = 0;
  bit last_acc = 1'b0;

  always @(negedge clk) begin
    if (rst && !mac_rst) rst_lo_cnt++;
    if (rst && mac_rst && (mac_md != 16'h0 || mac_mr != 16'h0)) nz_cnt++;
  end

  typedef struct {
    logic [26:0] data;
    logic        err;
    int          slots;
    int          bub;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_vec(input int n, input logic [15:0] md, input logic [15:0] mr,
                          input int gap_at, input int gap_len);
    logic signed [15:0] smd, smr;
    logic signed [31:0] p;
    logic signed [39:0] sum;
    exp_t e;
    int used, guard;
    bit hs;
    smd = md;
    smr = mr;
    p = smd * smr;
    used = (n > FRAME_LEN) ? FRAME_LEN : n;
    sum = '0;
    for (int i = 0; i < used; i++) sum = sum + {{8{p[31]}}, p};
    e.data  = rnd(sum);
    e.err   = (n > FRAME_LEN);
    e.slots = (p != 0) ? used : 0;
    e.bub   = (gap_at > 0 && gap_at < n) ? gap_len : 0;
    sb.push_back(e);
    rst_lo_cnt = 0;
    nz_cnt = 0;
    last_acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at && gap_len > 0) begin
        s_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_md = md;
      s_mr = mr;
      s_last = (i == n - 1);
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 2000) begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!hs) begin
        chk("send_timeout", 32'(hs), 32'd1);
        break;
      end
      if (i == n - 1) last_acc = 1'b1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic get_result(input int hold);
    exp_t e;
    logic [26:0] d0;
    int guard;
    bit stable;
    guard = 0;
    while (!res_valid && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!res_valid) begin
      chk("res_timeout", 32'(res_valid), 32'd1);
      return;
    end
    d0 = res_data;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      s_valid = 1'b1;
      s_last = 1'b0;
      @(posedge clk);
      #1;
      if (!res_valid || res_data != d0 || s_ready) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    s_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("res_data", 32'(res_data), 32'(e.data));
      chk("res_err", 32'(res_err), 32'(e.err));
      chk("mac_rst_pulse", 32'(rst_lo_cnt), 32'd1);
      chk("nonzero_slots", 32'(nz_cnt), 32'(e.slots));
`ifdef MAC_DRV_STATS_EN
      chk("res_bubbles", 32'(res_bubbles), 32'(e.bub));
`endif
    end
    guard = 0;
    while (res_valid && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("last_before_drop", 32'(last_acc), 32'd1);
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_mac_rst"}, 32'(mac_rst), 32'd0);
    chk({tag, "_mac_ops"}, {mac_md, mac_mr}, 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_res_err"}, 32'(res_err), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_md = '0;
    s_mr = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 4 pairs back to back: 4 * 0x2000 * 3 -> 12
    fork send_vec(4, 16'h2000, 16'h0003, -1, 0); get_result(0); join
    // same with a 2-cycle bubble between pairs 2 and 3
    fork send_vec(4, 16'h2000, 16'h0003, 2, 2); get_result(0); join
    // single negative pair -> -1
    fork send_vec(1, 16'hE000, 16'h0001, -1, 0); get_result(0); join
    // s_last on the final slot: full frame, no error -> 16
    fork send_vec(256, 16'h0010, 16'h0020, -1, 0); get_result(0); join
    // overflow: 300 pairs, only the first 256 counted -> 2048, err
    fork send_vec(300, 16'h0100, 16'h0100, -1, 0); get_result(0); join
    // recovery after overflow -> 6
    fork send_vec(3, 16'h1000, 16'h0004, -1, 0); get_result(0); join
    // consumer stalls 10 cycles with a new vector waiting -> 20
    fork send_vec(4, 16'h2000, 16'h0005, -1, 0); get_result(10); join

    // reset in the middle of STREAM
    s_valid = 1'b1;
    s_md = 16'h1234;
    s_mr = 16'h0002;
    s_last = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("mid_rst");
    rst = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("no_res_after_rst", 32'(res_valid), 32'd0);
    // next vector after reset -> 8
    fork send_vec(2, 16'h4000, 16'h0002, -1, 0); get_result(0); join

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
